// File: rtl/cpu_defs.sv
// Shared CPU definitions: control-word bit map, opcodes, flag indices, instruction lengths.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package cpu_defs;

  // Control word layout, one bit per control line, MSB first.
  localparam int CW_WIDTH = 16;
  typedef logic [CW_WIDTH-1:0] cw_t;

  localparam int HALT              = 15;
  localparam int MEMORY_ADDRESS_IN = 14;
  localparam int RAM_IN            = 13;
  localparam int RAM_OUT           = 12;
  localparam int INSTRUCTION_OUT   = 11;
  localparam int INSTRUCTION_IN    = 10;
  localparam int A_IN              = 9;
  localparam int A_OUT             = 8;
  localparam int SUM_OUT           = 7;
  localparam int SUBTRACT          = 6;
  localparam int B_IN              = 5;
  localparam int OUTPUT_IN         = 4;
  localparam int COUNTER_ENABLE    = 3;
  localparam int COUNTER_OUT       = 2;
  localparam int JUMP              = 1;
  localparam int FLAGS_IN          = 0;

  // One-hot masks so decode tables read as OR-ed control lines.
  localparam cw_t CW_HLT = cw_t'(1) << HALT;
  localparam cw_t CW_MI  = cw_t'(1) << MEMORY_ADDRESS_IN;
  localparam cw_t CW_RI  = cw_t'(1) << RAM_IN;
  localparam cw_t CW_RO  = cw_t'(1) << RAM_OUT;
  localparam cw_t CW_IO  = cw_t'(1) << INSTRUCTION_OUT;
  localparam cw_t CW_II  = cw_t'(1) << INSTRUCTION_IN;
  localparam cw_t CW_AI  = cw_t'(1) << A_IN;
  localparam cw_t CW_AO  = cw_t'(1) << A_OUT;
  localparam cw_t CW_EO  = cw_t'(1) << SUM_OUT;
  localparam cw_t CW_SU  = cw_t'(1) << SUBTRACT;
  localparam cw_t CW_BI  = cw_t'(1) << B_IN;
  localparam cw_t CW_OI  = cw_t'(1) << OUTPUT_IN;
  localparam cw_t CW_CE  = cw_t'(1) << COUNTER_ENABLE;
  localparam cw_t CW_CO  = cw_t'(1) << COUNTER_OUT;
  localparam cw_t CW_J   = cw_t'(1) << JUMP;
  localparam cw_t CW_FI  = cw_t'(1) << FLAGS_IN;

  // Flag register bit positions.
  localparam int FLAG_CARRY = 0;
  localparam int FLAG_ZERO  = 1;

  // Opcodes; values not listed decode as NOP.
  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  // Sequencer run state: running microsteps, or parked after HLT.
  typedef enum logic {
    SEQ_RUN    = 1'b0,
    SEQ_HALTED = 1'b1
  } seq_state_e;

  // Total microsteps (fetch included) an opcode needs before returning to fetch.
  function automatic logic [3:0] instr_length(input logic [3:0] op);
    case (op)
      OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: instr_length = 4'd3;
      OP_LDA, OP_STA:                               instr_length = 4'd4;
      OP_ADD, OP_SUB:                               instr_length = 4'd5;
      default:                                      instr_length = 4'd2;
    endcase
  endfunction

endpackage

// File: rtl/microstep_counter.sv
// Microstep counter: advances on falling clk, wraps at last_step, parks on halt_req until clear.
// Latency: step/halted update one falling edge after inputs settle; clear acts immediately.
// Backpressure: none; halted freezes the count instead of stalling upstream.
module microstep_counter #(
  parameter  int MAX_STEPS  = 5,
  localparam int STEP_WIDTH = $clog2(MAX_STEPS)
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic [STEP_WIDTH-1:0] last_step,
  input  logic                  halt_req,
  output logic [STEP_WIDTH-1:0] step,
  output logic                  halted
);
  import cpu_defs::*;

  // Anything at or past the final legal step returns to fetch, even a corrupted count.
  localparam logic [STEP_WIDTH-1:0] STEP_CEIL = STEP_WIDTH'(MAX_STEPS - 1);

  seq_state_e            state_q, state_d;
  logic [STEP_WIDTH-1:0] step_q, step_d;

  // State register on the falling edge, so steps change mid-way between IR loads.
  always_ff @(negedge clk or posedge clear) begin
    if (clear) begin
      state_q <= SEQ_RUN;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  // Next state: halt has priority, then end-of-instruction wrap, then increment.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      SEQ_HALTED: begin
        state_d = SEQ_HALTED;
        step_d  = step_q;
      end
      SEQ_RUN: begin
        if (halt_req) begin
          state_d = SEQ_HALTED;
        end else if ((step_q >= last_step) || (step_q >= STEP_CEIL)) begin
          step_d = '0;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
    endcase
  end

  assign step   = step_q;
  assign halted = (state_q == SEQ_HALTED);

endmodule

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: instruction register, microstep counter and control-word decode.
// Latency: IR loads on rising clk, step advances on falling clk, decode is combinational.
// Backpressure: none; HLT parks the sequencer until clear. Build option MICROSTEP_EARLY_END_EN.
module microcode_sequencer #(
  parameter  int DATA_WIDTH   = 8,
  parameter  int OPCODE_WIDTH = 4,
  parameter  int CW_WIDTH     = 16,
  parameter  int MAX_STEPS    = 5,
  localparam int STEP_WIDTH   = $clog2(MAX_STEPS)
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [1:0]            flags,
  input  logic [DATA_WIDTH-1:0] bus_in,
  input  logic [CW_WIDTH-1:0]   control_word_in,
  output logic [DATA_WIDTH-1:0] bus_out,
  output logic [CW_WIDTH-1:0]   control_word_out,
  output logic [STEP_WIDTH-1:0] step_out,
  output logic                  halted
);
  import cpu_defs::*;

  localparam int OPERAND_WIDTH = DATA_WIDTH - OPCODE_WIDTH;
  // Opcode view at least 4 bits wide so it can be compared against the opcode table.
  localparam int OPX = (OPCODE_WIDTH > 4) ? OPCODE_WIDTH : 4;

  localparam logic [STEP_WIDTH-1:0] S0 = STEP_WIDTH'(0);
  localparam logic [STEP_WIDTH-1:0] S1 = STEP_WIDTH'(1);
  localparam logic [STEP_WIDTH-1:0] S2 = STEP_WIDTH'(2);
  localparam logic [STEP_WIDTH-1:0] S3 = STEP_WIDTH'(3);
  localparam logic [STEP_WIDTH-1:0] S4 = STEP_WIDTH'(4);

  if (CW_WIDTH != cpu_defs::CW_WIDTH) begin : g_cw_width_check
    $error("CW_WIDTH must match cpu_defs::CW_WIDTH");
  end
  if (MAX_STEPS < 5) begin : g_max_steps_check
    $error("MAX_STEPS must be at least 5");
  end

  logic [DATA_WIDTH-1:0] ir;
  logic [OPX-1:0]        opcode_x;
  logic [3:0]            op;
  logic [STEP_WIDTH-1:0] step;
  logic [STEP_WIDTH-1:0] last_step;
  logic                  halt_req;
  cw_t                   cw;
  logic                  unused_cw_in;

  // Only INSTRUCTION_IN / INSTRUCTION_OUT matter here; the rest of the bus is for other units.
  assign unused_cw_in = ^control_word_in;

  // Instruction register loads from the bus on rising clk when INSTRUCTION_IN is asserted.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      ir <= '0;
    end else if (control_word_in[INSTRUCTION_IN]) begin
      ir <= bus_in;
    end
  end

  // Opcodes beyond the 4-bit table (wide OPCODE_WIDTH) fall back to NOP.
  assign opcode_x = OPX'(ir[DATA_WIDTH-1 -: OPCODE_WIDTH]);
  assign op       = ((opcode_x >> 4) == '0) ? opcode_x[3:0] : OP_NOP;

`ifdef MICROSTEP_EARLY_END_EN
  assign last_step = STEP_WIDTH'(instr_length(op) - 4'd1);
`else
  assign last_step = STEP_WIDTH'(MAX_STEPS - 1);
`endif

  // HLT parks at step 2, after its HALT word has been on the bus for one step.
  assign halt_req = (op == OP_HLT) && (step == S2);

  microstep_counter #(
    .MAX_STEPS (MAX_STEPS)
  ) u_counter (
    .clk       (clk),
    .clear     (clear),
    .last_step (last_step),
    .halt_req  (halt_req),
    .step      (step),
    .halted    (halted)
  );

  // Microcode decode: fetch for steps 0-1, opcode table after; flags feed JC/JZ live.
  always_comb begin
    cw = '0;
    if (halted) begin
      cw = CW_HLT;
    end else if (step == S0) begin
      cw = CW_CO | CW_MI;
    end else if (step == S1) begin
      cw = CW_RO | CW_II | CW_CE;
    end else begin
      case (op)
        OP_LDA: begin
          if (step == S2)      cw = CW_MI | CW_IO;
          else if (step == S3) cw = CW_RO | CW_AI;
        end
        OP_ADD: begin
          if (step == S2)      cw = CW_MI | CW_IO;
          else if (step == S3) cw = CW_RO | CW_BI;
          else if (step == S4) cw = CW_AI | CW_EO | CW_FI;
        end
        OP_SUB: begin
          if (step == S2)      cw = CW_MI | CW_IO;
          else if (step == S3) cw = CW_RO | CW_BI;
          else if (step == S4) cw = CW_AI | CW_EO | CW_SU | CW_FI;
        end
        OP_STA: begin
          if (step == S2)      cw = CW_MI | CW_IO;
          else if (step == S3) cw = CW_RI | CW_AO;
        end
        OP_LDI: begin
          if (step == S2) cw = CW_IO | CW_AI;
        end
        OP_JMP: begin
          if (step == S2) cw = CW_IO | CW_J;
        end
        OP_JC: begin
          if ((step == S2) && flags[FLAG_CARRY]) cw = CW_IO | CW_J;
        end
        OP_JZ: begin
          if ((step == S2) && flags[FLAG_ZERO]) cw = CW_IO | CW_J;
        end
        OP_OUT: begin
          if (step == S2) cw = CW_AO | CW_OI;
        end
        OP_HLT: begin
          if (step == S2) cw = CW_HLT;
        end
        default: cw = '0;
      endcase
    end
  end

  assign control_word_out = enable ? CW_WIDTH'(cw) : 'z;
  assign bus_out          = control_word_in[INSTRUCTION_OUT]
                            ? {{OPCODE_WIDTH{1'b0}}, ir[OPERAND_WIDTH-1:0]} : 'z;
  assign step_out         = step;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Bench for microcode_sequencer: vector table, random instructions vs reference model, corner sequences.
// Latency: outputs sampled 1 time unit after each falling edge, once the new step has settled.
// Backpressure: n/a; the control bus is looped back as in the real CPU unless the bench overrides it.
module tb_microcode_sequencer;

  localparam int MAXS = 5;
`ifdef MICROSTEP_EARLY_END_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  // Control lines, written out independently of the design package.
  localparam logic [15:0] B_HLT = 16'h8000, B_MI = 16'h4000, B_RI = 16'h2000, B_RO = 16'h1000;
  localparam logic [15:0] B_IO  = 16'h0800, B_II = 16'h0400, B_AI = 16'h0200, B_AO = 16'h0100;
  localparam logic [15:0] B_EO  = 16'h0080, B_SU = 16'h0040, B_BI = 16'h0020, B_OI = 16'h0010;
  localparam logic [15:0] B_CE  = 16'h0008, B_CO = 16'h0004, B_J  = 16'h0002, B_FI = 16'h0001;
  localparam logic [15:0] F0 = B_CO | B_MI;
  localparam logic [15:0] F1 = B_RO | B_II | B_CE;

  logic        clk, clear, enable;
  logic [1:0]  flags;
  logic [7:0]  bus_in;
  logic [15:0] cw_manual;
  wire  [15:0] cw_in;
  wire  [7:0]  bus_out;
  wire  [15:0] cw_out;
  wire  [2:0]  step_out;
  wire         halted;

  // The resolved control bus is the sequencer's own word unless the bench takes over.
  assign cw_in = enable ? cw_out : cw_manual;

  microcode_sequencer #(
    .DATA_WIDTH   (8),
    .OPCODE_WIDTH (4),
    .CW_WIDTH     (16),
    .MAX_STEPS    (MAXS)
  ) dut (
    .clk              (clk),
    .clear            (clear),
    .enable           (enable),
    .flags            (flags),
    .bus_in           (bus_in),
    .control_word_in  (cw_in),
    .bus_out          (bus_out),
    .control_word_out (cw_out),
    .step_out         (step_out),
    .halted           (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  // Reference microcode: per-opcode word for each step, plus instruction length.
  logic [15:0] ucode [16][MAXS];
  int          len_tab [16];

  task automatic init_model();
    for (int o = 0; o < 16; o++) begin
      len_tab[o] = 2;
      for (int s = 0; s < MAXS; s++) ucode[o][s] = 16'h0000;
    end
    ucode[1][2]  = B_MI | B_IO;  ucode[1][3] = B_RO | B_AI;  len_tab[1] = 4;
    ucode[2][2]  = B_MI | B_IO;  ucode[2][3] = B_RO | B_BI;  ucode[2][4] = B_AI | B_EO | B_FI;  len_tab[2] = 5;
    ucode[3][2]  = B_MI | B_IO;  ucode[3][3] = B_RO | B_BI;  ucode[3][4] = B_AI | B_EO | B_FI | B_SU;  len_tab[3] = 5;
    ucode[4][2]  = B_MI | B_IO;  ucode[4][3] = B_RI | B_AO;  len_tab[4] = 4;
    ucode[5][2]  = B_IO | B_AI;  len_tab[5] = 3;
    ucode[6][2]  = B_IO | B_J;   len_tab[6] = 3;
    ucode[7][2]  = B_IO | B_J;   len_tab[7] = 3;
    ucode[8][2]  = B_IO | B_J;   len_tab[8] = 3;
    ucode[14][2] = B_AO | B_OI;  len_tab[14] = 3;
    ucode[15][2] = B_HLT;        len_tab[15] = 3;
  endtask

  function automatic logic [15:0] model_word(input logic [7:0] ir, input int s, input logic [1:0] fl);
    logic [3:0]  op;
    logic [15:0] w;
    op = ir[7:4];
    if (s == 0) return F0;
    if (s == 1) return F1;
    w = ucode[op][s];
    if (op == 4'h7 && !fl[0]) w = 16'h0000;
    if (op == 4'h8 && !fl[1]) w = 16'h0000;
    return w;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // A released tri-state reads as Z in 4-state simulators and as 0 in 2-state ones.
  task automatic chk_float(input string nm, input logic [31:0] got);
    checks++;
    if (!($isunknown(got) || got == 32'h0)) begin
      errors++;
      $display("FAIL %s: got %0h expected high-Z", nm, got);
    end
  endtask

  task automatic advance();
    @(negedge clk);
    #1;
  endtask

  // Runs one instruction from step 0 to the next fetch, checking every step.
  task automatic run_instr(input string nm, input logic [7:0] ir, input logic [1:0] fl,
                           input int len, input logic [15:0] w2, input logic [15:0] w3,
                           input logic [15:0] w4);
    int          n;
    logic [15:0] exp;
    bus_in = ir;
    flags  = fl;
    n = EARLY ? len : MAXS;
    chk($sformatf("%s halted", nm), halted, 0);
    for (int s = 0; s < n; s++) begin
      exp = (s == 0) ? F0 : (s == 1) ? F1 : (s == 2) ? w2 : (s == 3) ? w3 : w4;
      chk($sformatf("%s ir=%0h step@%0d", nm, ir, s), step_out, s);
      chk($sformatf("%s ir=%0h cw@%0d", nm, ir, s), cw_out, exp);
      if ((exp & B_IO) != 16'h0) chk($sformatf("%s ir=%0h bus@%0d", nm, ir, s), bus_out, {4'h0, ir[3:0]});
      else if (s == 0) chk_float($sformatf("%s ir=%0h bus float", nm, ir), bus_out);
      advance();
    end
    chk($sformatf("%s ir=%0h back to fetch", nm, ir), step_out, 0);
  endtask

  typedef struct {
    logic [7:0]  ir;
    logic [1:0]  fl;
    int          len;
    logic [15:0] w2;
    logic [15:0] w3;
    logic [15:0] w4;
  } vec_t;

  vec_t vecs [16];

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  rir;
    logic [1:0]  rfl;
    logic [3:0]  rop;
    logic [3:0]  rarg;

    vecs[0]  = '{8'h1A, 2'b00, 4, 16'h4800, 16'h1200, 16'h0000};
    vecs[1]  = '{8'h2C, 2'b00, 5, 16'h4800, 16'h1020, 16'h0281};
    vecs[2]  = '{8'h33, 2'b01, 5, 16'h4800, 16'h1020, 16'h02C1};
    vecs[3]  = '{8'h47, 2'b00, 4, 16'h4800, 16'h2100, 16'h0000};
    vecs[4]  = '{8'h59, 2'b00, 3, 16'h0A00, 16'h0000, 16'h0000};
    vecs[5]  = '{8'h6D, 2'b00, 3, 16'h0802, 16'h0000, 16'h0000};
    vecs[6]  = '{8'h75, 2'b01, 3, 16'h0802, 16'h0000, 16'h0000};
    vecs[7]  = '{8'h75, 2'b00, 3, 16'h0000, 16'h0000, 16'h0000};
    vecs[8]  = '{8'h75, 2'b10, 3, 16'h0000, 16'h0000, 16'h0000};
    vecs[9]  = '{8'h83, 2'b10, 3, 16'h0802, 16'h0000, 16'h0000};
    vecs[10] = '{8'h83, 2'b01, 3, 16'h0000, 16'h0000, 16'h0000};
    vecs[11] = '{8'hE0, 2'b00, 3, 16'h0110, 16'h0000, 16'h0000};
    vecs[12] = '{8'h00, 2'b00, 2, 16'h0000, 16'h0000, 16'h0000};
    vecs[13] = '{8'h00, 2'b00, 2, 16'h0000, 16'h0000, 16'h0000};
    vecs[14] = '{8'h9F, 2'b00, 2, 16'h0000, 16'h0000, 16'h0000};
    vecs[15] = '{8'hC4, 2'b11, 2, 16'h0000, 16'h0000, 16'h0000};

    init_model();
    clear = 1'b0; enable = 1'b1; flags = 2'b00; bus_in = 8'h00; cw_manual = 16'h0000;
    #1 clear = 1'b1;
    #1;
    chk("reset step", step_out, 0);
    chk("reset halted", halted, 0);
    chk("reset cw", cw_out, F0);
    chk_float("reset bus", bus_out);
    advance();
    clear = 1'b0;

    foreach (vecs[i])
      run_instr("vec", vecs[i].ir, vecs[i].fl, vecs[i].len, vecs[i].w2, vecs[i].w3, vecs[i].w4);

    for (int i = 0; i < 30; i++) begin
      rop  = 4'($urandom_range(0, 14));
      rarg = 4'($urandom_range(0, 15));
      rfl  = 2'($urandom_range(0, 3));
      rir  = {rop, rarg};
      run_instr("rand", rir, rfl, len_tab[rop], model_word(rir, 2, rfl),
                model_word(rir, 3, rfl), model_word(rir, 4, rfl));
    end

    // Carry flag dropping in the middle of JC's step 2 retracts JUMP in the same step.
    bus_in = 8'h75; flags = 2'b01;
    advance(); advance();
    chk("jc live step", step_out, 2);
    chk("jc live jump", cw_out, B_IO | B_J);
    chk("jc live bus", bus_out, 8'h05);
    flags = 2'b00; #1;
    chk("jc flag drop", cw_out, 16'h0000);
    flags = 2'b01; #1;
    chk("jc flag rise", cw_out, B_IO | B_J);
    repeat ((EARLY ? 3 : MAXS) - 2) advance();
    chk("jc live end", step_out, 0);

    // Clear in step 3 of ADD aborts at once and empties the IR.
    bus_in = 8'h2B; flags = 2'b00;
    advance(); advance(); advance();
    chk("add pre-clear step", step_out, 3);
    chk("add pre-clear cw", cw_out, B_RO | B_BI);
    clear = 1'b1; #1;
    chk("add clear step", step_out, 0);
    chk("add clear halted", halted, 0);
    chk("add clear cw", cw_out, F0);
    enable = 1'b0; cw_manual = B_IO; #1;
    chk("add clear ir", bus_out, 8'h00);
    enable = 1'b1; cw_manual = 16'h0000;
    advance();
    clear = 1'b0;
    run_instr("post-clear", 8'h00, 2'b00, 2, 16'h0000, 16'h0000, 16'h0000);

    // HLT parks at step 2 with HALT on the bus until clear.
    bus_in = 8'hF0;
    advance(); advance();
    chk("hlt step2", step_out, 2);
    chk("hlt word", cw_out, B_HLT);
    chk("hlt not yet halted", halted, 0);
    bus_in = 8'h1A;
    advance();
    chk("hlt halted", halted, 1);
    chk("hlt held step", step_out, 2);
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("hlt hold cw %0d", i), cw_out, B_HLT);
      chk($sformatf("hlt hold step %0d", i), step_out, 2);
      advance();
    end
    enable = 1'b0; cw_manual = 16'h0000; #1;
    chk_float("hlt disabled cw", cw_out);
    chk("hlt still halted", halted, 1);
    clear = 1'b1; #1;
    chk("hlt clear halted", halted, 0);
    chk("hlt clear step", step_out, 0);
    enable = 1'b1; #1;
    chk("hlt clear cw", cw_out, F0);
    advance();
    clear = 1'b0;
    run_instr("post-halt", 8'h59, 2'b00, 3, B_IO | B_AI, 16'h0000, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
